// File: rtl/ripple_count_monitor.sv
`default_nettype none
// ============================================================================
// Module   : ripple_count_monitor
// Brief    : Synchronises and glitch-filters an asynchronous ripple
//            down-counter, tracks its sequence and flags wraps and errors.
// Revision : 1.0 - initial release
// ============================================================================
module ripple_count_monitor #(
    parameter int CNT_W    = 2,
    parameter int WRAP_W   = 8,
    parameter int STABLE_N = 2
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [CNT_W-1:0]  cnt_in,
    input  logic              en,
    input  logic              err_clr,
    output logic [CNT_W-1:0]  cnt_q,
    output logic              cnt_vld,
    output logic              step_pulse,
    output logic              wrap_pulse,
    output logic [WRAP_W-1:0] wrap_cnt,
    output logic              err_skip,
    output logic              err_up
);

    localparam int                  c_STAB_W   = $clog2(STABLE_N + 1);
    localparam logic [c_STAB_W-1:0] c_STAB_MAX = c_STAB_W'(STABLE_N);
    localparam logic [c_STAB_W-1:0] c_STAB_ONE = c_STAB_W'(1);
    localparam logic [CNT_W-1:0]    c_CNT_ONE  = CNT_W'(1);
    localparam logic [WRAP_W-1:0]   c_WRAP_ONE = WRAP_W'(1);
    localparam logic [0:0]          c_ST_INIT  = 1'b0;
    localparam logic [0:0]          c_ST_TRACK = 1'b1;

    logic [CNT_W-1:0]    r_s1;
    logic [CNT_W-1:0]    r_s2;
    logic                r_s1_vld;
    logic [c_STAB_W-1:0] r_stab;
    logic [0:0]          r_state;

    logic [c_STAB_W-1:0] w_stab_nxt;
    logic                w_accept;
    logic [CNT_W-1:0]    w_dec;
    logic [CNT_W-1:0]    w_inc;
    logic                w_is_step;
    logic                w_is_up;

    // Run length of identical samples entering s2; the reset contents of
    // s1 are not a real sample and never count toward stability.
    always_comb begin
        w_stab_nxt = '0;
        if (r_s1_vld) begin
            if ((r_stab != '0) && (r_s1 == r_s2)) begin
                w_stab_nxt = (r_stab == c_STAB_MAX) ? r_stab : r_stab + c_STAB_ONE;
            end else begin
                w_stab_nxt = c_STAB_ONE;
            end
        end
    end

    assign w_accept  = (w_stab_nxt == c_STAB_MAX);
    assign w_dec     = cnt_q - c_CNT_ONE;
    assign w_inc     = cnt_q + c_CNT_ONE;
    // For a 1-bit counter dec == inc; the step interpretation takes precedence.
    assign w_is_step = (r_s2 == w_dec);
    assign w_is_up   = (r_s2 == w_inc) && !w_is_step;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_s1       <= '0;
            r_s2       <= '0;
            r_s1_vld   <= 1'b0;
            r_stab     <= '0;
            r_state    <= c_ST_INIT;
            cnt_q      <= '0;
            cnt_vld    <= 1'b0;
            step_pulse <= 1'b0;
            wrap_pulse <= 1'b0;
            wrap_cnt   <= '0;
            err_skip   <= 1'b0;
            err_up     <= 1'b0;
        end else begin
            r_s1       <= cnt_in;
            r_s2       <= r_s1;
            r_s1_vld   <= 1'b1;
            r_stab     <= w_stab_nxt;
            step_pulse <= 1'b0;
            wrap_pulse <= 1'b0;

            // Cleared first so a same-cycle error detection below wins.
            if (err_clr) begin
                err_skip <= 1'b0;
                err_up   <= 1'b0;
            end

            if (!en) begin
                r_state <= c_ST_INIT;
                cnt_vld <= 1'b0;
            end else if (w_accept) begin
                if (r_state == c_ST_INIT) begin
                    cnt_q   <= r_s2;
                    cnt_vld <= 1'b1;
                    r_state <= c_ST_TRACK;
                end else if (r_s2 != cnt_q) begin
                    cnt_q <= r_s2;
                    if (w_is_step) begin
                        step_pulse <= 1'b1;
                        if (cnt_q == '0) begin
                            wrap_pulse <= 1'b1;
                            wrap_cnt   <= wrap_cnt + c_WRAP_ONE;
                        end
                    end else if (w_is_up) begin
                        err_up <= 1'b1;
                    end else begin
                        err_skip <= 1'b1;
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire
